// File: rtl/spio_aer_pkt_arbiter_if.sv
// rtl/spio_aer_pkt_arbiter_if.sv - packet source/sink bundle for spio_aer_pkt_arbiter
//
// Signals (NUM_IN sources of PKT_W-bit packets, one output link):
//   src_en   [NUM_IN]       per-source enable, 0 = source ignored
//   in_data  [NUM_IN*PKT_W] source i packet at [i*PKT_W +: PKT_W]
//   in_vld   [NUM_IN]       per-source packet valid
//   in_rdy   [NUM_IN]       per-source packet accepted
//   out_data [PKT_W]        packet toward the SpiNNaker link
//   out_vld                 out_data valid
//   out_rdy                 link accepts packet
//   last_src [2]            source index of the packet in out_data
// Modports: master = arbiter side, slave = sources/link side.

`ifndef PKT_BITS
`define PKT_BITS 72
`endif

interface spio_aer_pkt_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int PKT_W  = `PKT_BITS
);
  logic [NUM_IN-1:0]       src_en;
  logic [NUM_IN*PKT_W-1:0] in_data;
  logic [NUM_IN-1:0]       in_vld;
  logic [NUM_IN-1:0]       in_rdy;
  logic [PKT_W-1:0]        out_data;
  logic                    out_vld;
  logic                    out_rdy;
  logic [1:0]              last_src;

  modport master (
    input  src_en, in_data, in_vld, out_rdy,
    output in_rdy, out_data, out_vld, last_src
  );

  modport slave (
    output src_en, in_data, in_vld, out_rdy,
    input  in_rdy, out_data, out_vld, last_src
  );
endinterface

// File: rtl/spio_aer_pkt_arbiter.sv
// rtl/spio_aer_pkt_arbiter.sv - arbitrates NUM_IN AER packet sources onto one SpiNNaker link
//
// Parameters: NUM_IN (2..4 sources), PKT_W (packet width, default `PKT_BITS).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  spio_aer_pkt_arbiter_if.master (src_en, in_data, in_vld, in_rdy,
//        out_data, out_vld, out_rdy, last_src)
// Build option: SPIO_ARB_FIXED_PRI_EN defined selects fixed lowest-index
// priority instead of round-robin.

`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module spio_aer_pkt_arbiter #(
  parameter int NUM_IN = 4,
  parameter int PKT_W  = `PKT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  spio_aer_pkt_arbiter_if.master bus
);

  typedef enum logic {ARB_ST, SEND_ST} state_t;

  state_t            state;
  logic [1:0]        grant;
  logic [PKT_W-1:0]  out_data_q;
  logic              out_vld_q;
  logic [1:0]        last_src_q;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] in_rdy_c;
  logic [1:0]        nxt_grant;
  logic              any_req;
  logic              xfer;
  logic [1:0]        grant_inc;

`ifndef SPIO_ARB_FIXED_PRI_EN
  logic [1:0]        rr_ptr;
`endif

  assign req     = bus.in_vld & bus.src_en;
  assign any_req = |req;

  // Wrap grant+1 explicitly so NUM_IN=3 goes 2 -> 0 and indexes >= NUM_IN never appear.
  assign grant_inc = (grant == 2'(NUM_IN - 1)) ? 2'd0 : grant + 2'd1;

`ifdef SPIO_ARB_FIXED_PRI_EN
  // Lowest-index enabled requester wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    nxt_grant = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (req[k]) nxt_grant = 2'(k);
    end
  end
`else
  // First requester at or after rr_ptr, wrapping past NUM_IN-1 back to 0.
  always_comb begin
    logic       found;
    int         idx_i;
    logic [1:0] idx;
    nxt_grant = '0;
    found     = 1'b0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NUM_IN) idx_i = idx_i - NUM_IN;
      idx = idx_i[1:0];
      if (!found && req[idx]) begin
        nxt_grant = idx;
        found     = 1'b1;
      end
    end
  end
`endif

  // Only the granted source sees ready, and only while it is still enabled, so a
  // source disabled mid-grant never observes a handshake that is not a transfer.
  always_comb begin
    in_rdy_c = '0;
    if (state == SEND_ST && bus.src_en[grant]) begin
      in_rdy_c[grant] = ~out_vld_q | bus.out_rdy;
    end
  end

  assign xfer = (state == SEND_ST) & bus.in_vld[grant] & in_rdy_c[grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_ST;
      grant      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      last_src_q <= '0;
`ifndef SPIO_ARB_FIXED_PRI_EN
      rr_ptr     <= '0;
`endif
    end else begin
      // Drain first; a load later in this block overrides the clear.
      if (out_vld_q && bus.out_rdy) out_vld_q <= 1'b0;

      case (state)
        ARB_ST: begin
          if (any_req) begin
            grant <= nxt_grant;
            state <= SEND_ST;
          end
        end
        SEND_ST: begin
          if (xfer) begin
            out_data_q <= bus.in_data[int'(grant)*PKT_W +: PKT_W];
            out_vld_q  <= 1'b1;
            last_src_q <= grant;
`ifndef SPIO_ARB_FIXED_PRI_EN
            rr_ptr     <= grant_inc;
`endif
            state      <= ARB_ST;
          end else if (!bus.in_vld[grant] || !bus.src_en[grant]) begin
            // Requester withdrew: abandon the grant, pointer stays put.
            state <= ARB_ST;
          end
          // Otherwise the link is stalled; keep the grant and wait.
        end
        default: state <= ARB_ST;
      endcase
    end
  end

`ifdef SPIO_ARB_FIXED_PRI_EN
  logic unused_inc;
  assign unused_inc = ^grant_inc;
`endif

  assign bus.in_rdy   = in_rdy_c;
  assign bus.out_data = out_data_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.last_src = last_src_q;

endmodule

// File: tb/tb_spio_aer_pkt_arbiter.sv
// tb/tb_spio_aer_pkt_arbiter.sv - self-checking bench for spio_aer_pkt_arbiter

`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module tb_spio_aer_pkt_arbiter;
  localparam int NUM_IN = 4;
  localparam int PKT_W  = `PKT_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spio_aer_pkt_arbiter_if #(.NUM_IN(NUM_IN), .PKT_W(PKT_W)) bus ();

  spio_aer_pkt_arbiter #(.NUM_IN(NUM_IN), .PKT_W(PKT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] src_en;
    logic [3:0] in_vld;
    logic       out_rdy;
    logic [3:0] exp_in_rdy;
    logic       exp_out_vld;
    logic [1:0] exp_last_src;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [PKT_W-1:0] pkt(input int i);
    logic [PKT_W-1:0] p;
    p = '0;
    p[7:0]          = 8'hA5;
    p[15:8]         = 8'(i);
    p[PKT_W-1 -: 8] = 8'hC3;
    return p;
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] en, input logic [3:0] vld, input logic ordy,
                     input logic [3:0] e_rdy, input logic e_ov, input logic [1:0] e_ls);
    vec_t v;
    v.src_en = en; v.in_vld = vld; v.out_rdy = ordy;
    v.exp_in_rdy = e_rdy; v.exp_out_vld = e_ov; v.exp_last_src = e_ls;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.src_en = 4'b1111; bus.in_vld = '0; bus.out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs 12 cycles with continuous requests and compares the load sequence.
  task automatic run_seq(input string name, input logic [3:0] en, input int exp_seq[6]);
    int got[$];
    int rdy2_seen;
    rdy2_seen = 0;
    do_reset();
    bus.src_en = en; bus.in_vld = 4'b1111; bus.out_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.in_rdy[2] && !en[2]) rdy2_seen++;
      @(posedge clk); #1;
      if (bus.out_vld) begin
        got.push_back(int'(bus.last_src));
        chk_d($sformatf("%s data%0d", name, got.size() - 1), bus.out_data, pkt(int'(bus.last_src)));
      end
      @(negedge clk);
    end
    chk_i($sformatf("%s count", name), got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk_i($sformatf("%s src%0d", name, i), (i < got.size()) ? got[i] : -1, exp_seq[i]);
    end
    chk_i($sformatf("%s disabled_rdy", name), rdy2_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seq_all[6];
    int seq_en[6];

    bus.src_en = 4'b1111; bus.in_vld = '0; bus.out_rdy = 1'b1;
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*PKT_W +: PKT_W] = pkt(i);

    // Cycle-by-cycle table; expected outputs are sampled after the rising edge.
    add(4'hF, 4'b0000, 1, 4'b0000, 0, 0);
    add(4'hF, 4'b0100, 1, 4'b0000, 0, 0);
    add(4'hF, 4'b0100, 1, 4'b0100, 1, 2);
    add(4'hF, 4'b0000, 1, 4'b0000, 0, 2);
    add(4'hF, 4'b0011, 0, 4'b0000, 0, 2);
    add(4'hF, 4'b0011, 0, 4'b0001, 1, 0);
    add(4'hF, 4'b0010, 0, 4'b0000, 1, 0);
    for (int i = 0; i < 8; i++) add(4'hF, 4'b0010, 0, 4'b0000, 1, 0);
    add(4'hF, 4'b0010, 1, 4'b0010, 1, 1);
    add(4'hF, 4'b0000, 1, 4'b0000, 0, 1);
    add(4'hF, 4'b1000, 1, 4'b0000, 0, 1);
    add(4'hF, 4'b0000, 1, 4'b1000, 0, 1);
    add(4'hF, 4'b0101, 1, 4'b0000, 0, 1);
`ifdef SPIO_ARB_FIXED_PRI_EN
    add(4'hF, 4'b0101, 1, 4'b0001, 1, 0);
    add(4'hF, 4'b0000, 1, 4'b0000, 0, 0);
    seq_all = '{0, 0, 0, 0, 0, 0};
    seq_en  = '{0, 0, 0, 0, 0, 0};
`else
    add(4'hF, 4'b0101, 1, 4'b0100, 1, 2);
    add(4'hF, 4'b0000, 1, 4'b0000, 0, 2);
    seq_all = '{0, 1, 2, 3, 0, 1};
    seq_en  = '{0, 1, 3, 0, 1, 3};
`endif

    #1;
    chk_i("reset out_vld", int'(bus.out_vld), 0);
    chk_i("reset in_rdy", int'(bus.in_rdy), 0);
    chk_i("reset last_src", int'(bus.last_src), 0);
    chk_d("reset out_data", bus.out_data, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[n]) begin
      @(negedge clk);
      bus.src_en = tbl[n].src_en; bus.in_vld = tbl[n].in_vld; bus.out_rdy = tbl[n].out_rdy;
      #1;
      chk_i($sformatf("row%0d in_rdy", n), int'(bus.in_rdy), int'(tbl[n].exp_in_rdy));
      @(posedge clk); #1;
      chk_i($sformatf("row%0d out_vld", n), int'(bus.out_vld), int'(tbl[n].exp_out_vld));
      chk_i($sformatf("row%0d last_src", n), int'(bus.last_src), int'(tbl[n].exp_last_src));
      if (tbl[n].exp_out_vld)
        chk_d($sformatf("row%0d out_data", n), bus.out_data, pkt(int'(tbl[n].exp_last_src)));
    end

    run_seq("all4", 4'b1111, seq_all);
    run_seq("en1011", 4'b1011, seq_en);

    // Asynchronous reset while a packet is held and source 1 is granted.
    do_reset();
    bus.src_en = 4'b1111; bus.in_vld = 4'b0011; bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_i("pre_rst out_vld", int'(bus.out_vld), 1);
    @(negedge clk);
    bus.out_rdy = 1'b1;
    #1;
    chk_i("pre_rst in_rdy", int'(bus.in_rdy), 2);
    rst = 1'b1;
    #1;
    chk_i("async_rst out_vld", int'(bus.out_vld), 0);
    chk_i("async_rst in_rdy", int'(bus.in_rdy), 0);
    chk_d("async_rst out_data", bus.out_data, '0);
    chk_i("async_rst last_src", int'(bus.last_src), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_i("post_rst out_vld0", int'(bus.out_vld), 0);
    @(posedge clk); #1;
    chk_i("post_rst out_vld1", int'(bus.out_vld), 1);
    chk_i("post_rst last_src", int'(bus.last_src), 0);
    chk_d("post_rst out_data", bus.out_data, pkt(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
